// File: rtl/fpga_scoreboard_pkg.sv
// Command, reply and flash codes plus the state types shared by the scoreboard top and its UART.
package fpga_scoreboard_pkg;

   localparam logic [7:0] CMD_READ      = 8'h52;
   localparam logic [7:0] CMD_WRITE     = 8'h57;
   localparam logic [7:0] RSP_OK        = 8'h4B;
   localparam logic [7:0] RSP_ERR       = 8'h45;
   localparam logic [7:0] RSP_BAD       = 8'h3F;
   localparam logic [7:0] FL_PROGRAM    = 8'h40;
   localparam logic [7:0] FL_READ_ARRAY = 8'hFF;

   typedef enum logic [3:0] {
      StIdle,
      StGetAddr,
      StGetData,
      StRdStrobe,
      StWrCmd,
      StWrData,
      StWaitSts,
      StWrRestore,
      StReply
   } state_e;

   // Sub-steps of one flash bus write: address/data setup, WE strobe, hold.
   typedef enum logic [1:0] {
      PhSetup,
      PhStrobe,
      PhHold
   } phase_e;

   typedef enum logic [1:0] {
      RxIdle,
      RxStart,
      RxData,
      RxStop
   } rx_state_e;

endpackage

// File: rtl/sb_uart.sv
// 8N1 UART receiver and transmitter; the receive input must already be synchronised.
module sb_uart
   import fpga_scoreboard_pkg::*;
#(
   parameter int unsigned BIT_CYC = 434
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rxd_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic [7:0] tx_data_i,
   input  logic       tx_send_i,
   output logic       tx_busy_o,
   output logic       txd_o
);

   localparam int unsigned CNT_W = $clog2(BIT_CYC);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);

   rx_state_e        rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_idx_q, rx_idx_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_prev_q, rx_prev_d;

   logic             tx_busy_q, tx_busy_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]       tx_left_q, tx_left_d;
   logic [8:0]       tx_shift_q, tx_shift_d;
   logic             txd_q, txd_d;

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 1'b1;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_valid_d = 1'b0;
      rx_prev_d  = rxd_i;
      unique case (rx_state_q)
         RxIdle: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rxd_i) rx_state_d = RxStart;
         end
         RxStart: begin
            // Line back high at mid start bit means a glitch, not a frame.
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_idx_d   = '0;
               rx_state_d = rxd_i ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rxd_i, rx_shift_q[7:1]};
               rx_idx_d   = rx_idx_q + 1'b1;
               if (rx_idx_q == 3'd7) rx_state_d = RxStop;
            end
         end
         RxStop: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_state_d = RxIdle;
               rx_valid_d = rxd_i;
            end
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_comb begin
      tx_busy_d  = tx_busy_q;
      tx_cnt_d   = tx_cnt_q + 1'b1;
      tx_left_d  = tx_left_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      if (!tx_busy_q) begin
         tx_cnt_d = '0;
         if (tx_send_i) begin
            tx_busy_d  = 1'b1;
            txd_d      = 1'b0;
            tx_shift_d = {1'b1, tx_data_i};
            tx_left_d  = 4'd9;
         end
      end else if (tx_cnt_q == BIT_LAST) begin
         tx_cnt_d = '0;
         if (tx_left_q != '0) begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[8:1]};
            tx_left_d  = tx_left_q - 4'd1;
         end else begin
            tx_busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_valid_q <= 1'b0;
         rx_prev_q  <= 1'b1;
         tx_busy_q  <= 1'b0;
         tx_cnt_q   <= '0;
         tx_left_q  <= '0;
         tx_shift_q <= '1;
         txd_q      <= 1'b1;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_valid_q <= rx_valid_d;
         rx_prev_q  <= rx_prev_d;
         tx_busy_q  <= tx_busy_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_left_q  <= tx_left_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
      end
   end

   assign rx_data_o  = rx_shift_q;
   assign rx_valid_o = rx_valid_q;
   assign tx_busy_o  = tx_busy_q;
   assign txd_o      = txd_q;

endmodule

// File: rtl/fpga_scoreboard_top.sv
// Scoreboard top: UART byte commands driving read/program cycles on a parallel NOR flash.
module fpga_scoreboard_top
   import fpga_scoreboard_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50000000,
   parameter int unsigned BAUD        = 115200,
   parameter int unsigned ACC_CYC     = 6,
   parameter int unsigned STS_TIMEOUT = 50000
) (
   input  logic       CLK_50MHZ,
   input  logic       BTN_WEST,
   input  logic       RS232_DCE_RXD,
   output logic       RS232_DCE_TXD,
   output logic [7:0] NF_A,
   inout  wire  [7:0] NF_D,
   output logic       NF_CE,
   output logic       NF_OE,
   output logic       NF_WE,
   output logic       NF_RP,
   output logic       NF_BYTE,
   output logic       NF_WP,
   input  logic       NF_STS
);

   localparam int unsigned BIT_CYC = CLK_HZ / BAUD;
   localparam int unsigned CNT_MAX = (STS_TIMEOUT > ACC_CYC) ? STS_TIMEOUT : ACC_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] ACC_LAST = CNT_W'(ACC_CYC - 1);
   localparam logic [CNT_W-1:0] STS_LAST = CNT_W'(STS_TIMEOUT - 1);

   logic             rxd_meta_q, rxd_sync_q, sts_meta_q, sts_sync_q, rp_q;
   state_e           state_q, state_d;
   phase_e           phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_write_q, is_write_d;
   logic [7:0]       addr_q, addr_d, data_q, data_d, reply_q, reply_d;
   logic             ce_q, ce_d, oe_q, oe_d, we_q, we_d, d_oe_q, d_oe_d;
   logic [7:0]       d_out_q, d_out_d;

   logic [7:0] rx_data;
   logic       rx_valid, tx_busy, tx_send;

   sb_uart #(
      .BIT_CYC (BIT_CYC)
   ) u_uart (
      .clk_i      (CLK_50MHZ),
      .rst_i      (BTN_WEST),
      .rxd_i      (rxd_sync_q),
      .rx_data_o  (rx_data),
      .rx_valid_o (rx_valid),
      .tx_data_i  (reply_q),
      .tx_send_i  (tx_send),
      .tx_busy_o  (tx_busy),
      .txd_o      (RS232_DCE_TXD)
   );

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      cnt_d      = cnt_q;
      is_write_d = is_write_q;
      addr_d     = addr_q;
      data_d     = data_q;
      reply_d    = reply_q;
      tx_send    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rx_valid) begin
               if (rx_data == CMD_READ) begin
                  is_write_d = 1'b0;
                  state_d    = StGetAddr;
               end else if (rx_data == CMD_WRITE) begin
                  is_write_d = 1'b1;
                  state_d    = StGetAddr;
               end else begin
                  reply_d = RSP_BAD;
                  state_d = StReply;
               end
            end
         end
         StGetAddr: begin
            if (rx_valid) begin
               addr_d  = rx_data;
               cnt_d   = '0;
               phase_d = PhSetup;
               state_d = is_write_q ? StGetData : StRdStrobe;
            end
         end
         StGetData: begin
            if (rx_valid) begin
               data_d  = rx_data;
               cnt_d   = '0;
               phase_d = PhSetup;
               state_d = StWrCmd;
            end
         end
         StRdStrobe: begin
            if (cnt_q == ACC_LAST) begin
               reply_d = NF_D;
               state_d = StReply;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StWrCmd, StWrData, StWrRestore: begin
            unique case (phase_q)
               PhSetup: begin
                  phase_d = PhStrobe;
                  cnt_d   = '0;
               end
               PhStrobe: begin
                  if (cnt_q == ACC_LAST) phase_d = PhHold;
                  else cnt_d = cnt_q + 1'b1;
               end
               PhHold: begin
                  phase_d = PhSetup;
                  cnt_d   = '0;
                  if (state_q == StWrCmd) state_d = StWrData;
                  else if (state_q == StWrData) state_d = StWaitSts;
                  else state_d = StReply;
               end
               default: phase_d = PhSetup;
            endcase
         end
         StWaitSts: begin
            // Read-array is restored even on timeout so the flash is left readable.
            if (sts_sync_q || cnt_q == STS_LAST) begin
               reply_d = sts_sync_q ? RSP_OK : RSP_ERR;
               phase_d = PhSetup;
               state_d = StWrRestore;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StReply: begin
            if (!tx_busy) begin
               tx_send = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Bus pins decode the next state so they come straight from flops.
   always_comb begin
      ce_d    = 1'b1;
      oe_d    = 1'b1;
      we_d    = 1'b1;
      d_oe_d  = 1'b0;
      d_out_d = d_out_q;
      unique case (state_d)
         StRdStrobe: begin
            ce_d = 1'b0;
            oe_d = 1'b0;
         end
         StWrCmd: begin
            d_oe_d  = 1'b1;
            d_out_d = FL_PROGRAM;
         end
         StWrData: begin
            d_oe_d  = 1'b1;
            d_out_d = data_d;
         end
         StWrRestore: begin
            d_oe_d  = 1'b1;
            d_out_d = FL_READ_ARRAY;
         end
         default: ;
      endcase
      if (d_oe_d && phase_d == PhStrobe) begin
         ce_d = 1'b0;
         we_d = 1'b0;
      end
   end

   always_ff @(posedge CLK_50MHZ) begin
      if (BTN_WEST) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         sts_meta_q <= 1'b0;
         sts_sync_q <= 1'b0;
         rp_q       <= 1'b0;
         state_q    <= StIdle;
         phase_q    <= PhSetup;
         cnt_q      <= '0;
         is_write_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         reply_q    <= '0;
         ce_q       <= 1'b1;
         oe_q       <= 1'b1;
         we_q       <= 1'b1;
         d_oe_q     <= 1'b0;
         d_out_q    <= '0;
      end else begin
         rxd_meta_q <= RS232_DCE_RXD;
         rxd_sync_q <= rxd_meta_q;
         sts_meta_q <= NF_STS;
         sts_sync_q <= sts_meta_q;
         rp_q       <= 1'b1;
         state_q    <= state_d;
         phase_q    <= phase_d;
         cnt_q      <= cnt_d;
         is_write_q <= is_write_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         reply_q    <= reply_d;
         ce_q       <= ce_d;
         oe_q       <= oe_d;
         we_q       <= we_d;
         d_oe_q     <= d_oe_d;
         d_out_q    <= d_out_d;
      end
   end

   assign NF_A    = addr_q;
   assign NF_D    = d_oe_q ? d_out_q : 8'hzz;
   assign NF_CE   = ce_q;
   assign NF_OE   = oe_q;
   assign NF_WE   = we_q;
   assign NF_RP   = rp_q;
   assign NF_BYTE = 1'b0;
   assign NF_WP   = 1'b1;

endmodule

// File: tb/tb_fpga_scoreboard_top.sv
// Directed bench for the scoreboard: UART host, NOR flash bus model and per-scenario checks.
module tb_fpga_scoreboard_top;

   // A faster baud keeps the 50000-cycle status timeout test within a short run.
   localparam int unsigned BAUD = 1000000;
   localparam int unsigned BIT  = 50000000 / BAUD;
   localparam int unsigned STS_TIMEOUT = 50000;

   logic clk = 1'b0;
   logic btn = 1'b1;
   logic rxd = 1'b1;
   logic sts = 1'b1;
   logic txd, ce, oe, we, rp, nbyte, wp;
   logic [7:0] a;
   wire  [7:0] nf_d;

   int checks = 0;
   int errors = 0;

   always #10 clk = ~clk;

   fpga_scoreboard_top #(
      .BAUD (BAUD)
   ) dut (
      .CLK_50MHZ     (clk),
      .BTN_WEST      (btn),
      .RS232_DCE_RXD (rxd),
      .RS232_DCE_TXD (txd),
      .NF_A          (a),
      .NF_D          (nf_d),
      .NF_CE         (ce),
      .NF_OE         (oe),
      .NF_WE         (we),
      .NF_RP         (rp),
      .NF_BYTE       (nbyte),
      .NF_WP         (wp),
      .NF_STS        (sts)
   );

   // Released bus floats high so a driven value is distinguishable from Z.
   for (genvar gi = 0; gi < 8; gi++) begin : g_pull
      pullup (nf_d[gi]);
   end

   logic [7:0] mem [256];
   assign nf_d = (!oe && !ce) ? mem[a] : 8'hzz;

   // Flash model and bus logger.
   int unsigned cyc = 0;
   logic we_prev = 1'b1, oe_prev = 1'b1, after_pend = 1'b0, prog_armed = 1'b0, mem_init = 1'b0;
   int we_len = 0, oe_len = 0, sts_cnt = 0, sts_delay = 20, overlap = 0, stop_err = 0;
   logic [7:0] we_a, we_dat, oe_a;
   logic [7:0] wr_a_q[$], wr_d_q[$], hold_q[$], after_q[$], rd_a_q[$];
   int wr_len_q[$], rd_len_q[$], fall_q[$], rise_q[$];

   always @(negedge clk) begin
      cyc++;
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
         mem_init = 1'b1;
      end
      if (sts_cnt > 0) begin
         sts_cnt--;
         if (sts_cnt == 0) sts = 1'b1;
      end
      if (!we && !oe) overlap++;
      if (!we) begin
         if (we_prev) fall_q.push_back(int'(cyc));
         we_len++;
         we_a   = a;
         we_dat = nf_d;
      end else if (!we_prev) begin
         wr_a_q.push_back(we_a);
         wr_d_q.push_back(we_dat);
         wr_len_q.push_back(we_len);
         hold_q.push_back(nf_d);
         rise_q.push_back(int'(cyc));
         we_len     = 0;
         after_pend = 1'b1;
         if (prog_armed) begin
            mem[we_a]  = mem[we_a] & we_dat;
            prog_armed = 1'b0;
            if (sts_delay > 0) sts_cnt = sts_delay;
         end else if (we_dat == 8'h40) begin
            prog_armed = 1'b1;
            sts        = 1'b0;
         end
      end else if (after_pend) begin
         after_q.push_back(nf_d);
         after_pend = 1'b0;
      end
      if (!oe) begin
         oe_len++;
         oe_a = a;
      end else if (!oe_prev) begin
         rd_a_q.push_back(oe_a);
         rd_len_q.push_back(oe_len);
         oe_len = 0;
      end
      if (!rp) begin
         prog_armed = 1'b0;
         sts_cnt    = 0;
         sts        = 1'b1;
      end
      we_prev = we;
      oe_prev = oe;
   end

   // UART host receiver on TXD.
   logic [7:0] reply_q[$];
   always begin
      @(negedge clk);
      if (!txd && !btn) begin
         logic [7:0] b;
         repeat (BIT / 2) @(negedge clk);
         if (!txd) begin
            for (int i = 0; i < 8; i++) begin
               repeat (BIT) @(negedge clk);
               b[i] = txd;
            end
            repeat (BIT) @(negedge clk);
            if (!txd) stop_err++;
            reply_q.push_back(b);
         end
      end
   end

   initial begin
      repeat (200000) @(negedge clk);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   task automatic uart_send(input logic [7:0] b);
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      rxd = 1'b1;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic wait_reply(input int budget, output logic got, output logic [7:0] b);
      got = 1'b0;
      b   = 8'h00;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (reply_q.size() > 0) begin
            got = 1'b1;
            b   = reply_q.pop_front();
         end
      end
   endtask

   task automatic clear_logs();
      wr_a_q.delete(); wr_d_q.delete(); wr_len_q.delete(); hold_q.delete(); after_q.delete();
      rd_a_q.delete(); rd_len_q.delete(); fall_q.delete(); rise_q.delete(); reply_q.delete();
   endtask

   task automatic test_reset();
      btn = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
      checks++; if (ce !== 1'b1) begin errors++; $display("FAIL reset_ce: got %b want 1", ce); end
      checks++; if (oe !== 1'b1) begin errors++; $display("FAIL reset_oe: got %b want 1", oe); end
      checks++; if (we !== 1'b1) begin errors++; $display("FAIL reset_we: got %b want 1", we); end
      checks++; if (rp !== 1'b0) begin errors++; $display("FAIL reset_rp: got %b want 0", rp); end
      checks++; if (a !== 8'h00) begin errors++; $display("FAIL reset_a: got %h want 00", a); end
      checks++; if (nf_d !== 8'hFF) begin errors++; $display("FAIL reset_d_released: got %h want FF", nf_d); end
      checks++; if (nbyte !== 1'b0) begin errors++; $display("FAIL nf_byte: got %b want 0", nbyte); end
      checks++; if (wp !== 1'b1) begin errors++; $display("FAIL nf_wp: got %b want 1", wp); end
      btn = 1'b0;
      @(negedge clk);
      checks++; if (rp !== 1'b1) begin errors++; $display("FAIL rp_release: got %b want 1", rp); end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_write();
      logic got;
      logic [7:0] b;
      logic [7:0] exp_d [3];
      exp_d = '{8'h40, 8'hA5, 8'hFF};
      clear_logs();
      sts_delay = 20;
      uart_send(8'h57); uart_send(8'h10); uart_send(8'hA5);
      wait_reply(20 * BIT + 200, got, b);
      checks++; if (!got || b !== 8'h4B) begin errors++; $display("FAIL write_reply: got %h (seen %b) want 4B", b, got); end
      checks++; if (wr_a_q.size() != 3) begin errors++; $display("FAIL write_count: got %0d want 3", wr_a_q.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (wr_a_q[i] !== 8'h10) begin errors++; $display("FAIL write_addr[%0d]: got %h want 10", i, wr_a_q[i]); end
            checks++; if (wr_d_q[i] !== exp_d[i]) begin errors++; $display("FAIL write_data[%0d]: got %h want %h", i, wr_d_q[i], exp_d[i]); end
            checks++; if (wr_len_q[i] != 6) begin errors++; $display("FAIL write_we_len[%0d]: got %0d want 6", i, wr_len_q[i]); end
            checks++; if (hold_q[i] !== exp_d[i]) begin errors++; $display("FAIL write_hold[%0d]: got %h want %h", i, hold_q[i], exp_d[i]); end
         end
         checks++; if (after_q[1] !== 8'hFF) begin errors++; $display("FAIL write_release: got %h want FF", after_q[1]); end
      end
      checks++; if (rd_a_q.size() != 0) begin errors++; $display("FAIL write_no_read: got %0d reads want 0", rd_a_q.size()); end
   endtask

   task automatic test_read();
      logic got;
      logic [7:0] b;
      clear_logs();
      uart_send(8'h52); uart_send(8'h10);
      wait_reply(20 * BIT + 200, got, b);
      checks++; if (!got || b !== 8'hA5) begin errors++; $display("FAIL read_reply: got %h (seen %b) want A5", b, got); end
      checks++; if (rd_a_q.size() != 1) begin errors++; $display("FAIL read_count: got %0d want 1", rd_a_q.size()); end
      else begin
         checks++; if (rd_a_q[0] !== 8'h10) begin errors++; $display("FAIL read_addr: got %h want 10", rd_a_q[0]); end
         checks++; if (rd_len_q[0] != 6) begin errors++; $display("FAIL read_oe_len: got %0d want 6", rd_len_q[0]); end
      end
      checks++; if (wr_a_q.size() != 0) begin errors++; $display("FAIL read_no_write: got %0d writes want 0", wr_a_q.size()); end
   endtask

   task automatic test_timeout();
      logic got;
      logic [7:0] b;
      int gap;
      clear_logs();
      sts_delay = -1;
      uart_send(8'h57); uart_send(8'h20); uart_send(8'h33);
      wait_reply(STS_TIMEOUT + 20 * BIT + 200, got, b);
      checks++; if (!got || b !== 8'h45) begin errors++; $display("FAIL timeout_reply: got %h (seen %b) want 45", b, got); end
      checks++; if (wr_a_q.size() != 3) begin errors++; $display("FAIL timeout_count: got %0d want 3", wr_a_q.size()); end
      else begin
         checks++; if (wr_d_q[1] !== 8'h33 || wr_a_q[1] !== 8'h20) begin errors++; $display("FAIL timeout_data: got %h@%h want 33@20", wr_d_q[1], wr_a_q[1]); end
         checks++; if (wr_d_q[2] !== 8'hFF || wr_a_q[2] !== 8'h20) begin errors++; $display("FAIL timeout_restore: got %h@%h want FF@20", wr_d_q[2], wr_a_q[2]); end
         gap = fall_q[2] - rise_q[1];
         checks++; if (gap < STS_TIMEOUT || gap > STS_TIMEOUT + 4) begin errors++; $display("FAIL timeout_wait: got %0d cycles want %0d..%0d", gap, STS_TIMEOUT, STS_TIMEOUT + 4); end
      end
      sts_delay = 20;
   endtask

   task automatic test_bad_cmd();
      logic got;
      logic [7:0] b;
      clear_logs();
      uart_send(8'h00);
      wait_reply(20 * BIT, got, b);
      checks++; if (!got || b !== 8'h3F) begin errors++; $display("FAIL bad_reply: got %h (seen %b) want 3F", b, got); end
      checks++; if (wr_a_q.size() + rd_a_q.size() != 0) begin errors++; $display("FAIL bad_no_strobe: got %0d strobes want 0", wr_a_q.size() + rd_a_q.size()); end
   endtask

   task automatic test_false_start();
      logic got;
      logic [7:0] b;
      clear_logs();
      rxd = 1'b0;
      repeat (BIT / 2 - 8) @(negedge clk);
      rxd = 1'b1;
      wait_reply(15 * BIT, got, b);
      checks++; if (got) begin errors++; $display("FAIL false_start_reply: got %h want none", b); end
      checks++; if (wr_a_q.size() + rd_a_q.size() != 0) begin errors++; $display("FAIL false_start_strobe: got %0d want 0", wr_a_q.size() + rd_a_q.size()); end
   endtask

   task automatic test_reset_mid_write();
      logic got, hit;
      logic [7:0] b;
      clear_logs();
      hit = 1'b0;
      uart_send(8'h57); uart_send(8'h30);
      fork
         uart_send(8'h44);
      join_none
      for (int i = 0; i < 20 * BIT && !hit; i++) begin
         @(negedge clk);
         if (wr_a_q.size() == 1 && !we) hit = 1'b1;
      end
      checks++; if (!hit) begin errors++; $display("FAIL abort_reach_wr_data: got no data strobe want one"); end
      btn = 1'b1;
      @(negedge clk);
      checks++; if (we !== 1'b1) begin errors++; $display("FAIL abort_we: got %b want 1", we); end
      checks++; if (ce !== 1'b1) begin errors++; $display("FAIL abort_ce: got %b want 1", ce); end
      checks++; if (nf_d !== 8'hFF) begin errors++; $display("FAIL abort_d_released: got %h want FF", nf_d); end
      checks++; if (rp !== 1'b0) begin errors++; $display("FAIL abort_rp: got %b want 0", rp); end
      repeat (3) @(negedge clk);
      btn = 1'b0;
      wait_reply(25 * BIT, got, b);
      checks++; if (got) begin errors++; $display("FAIL abort_reply: got %h want none", b); end
      checks++; if (wr_a_q.size() != 2) begin errors++; $display("FAIL abort_no_restore: got %0d writes want 2", wr_a_q.size()); end
   endtask

   task automatic test_bus_rules();
      checks++; if (overlap != 0) begin errors++; $display("FAIL we_oe_overlap: got %0d cycles want 0", overlap); end
      checks++; if (stop_err != 0) begin errors++; $display("FAIL tx_stop_bit: got %0d bad stops want 0", stop_err); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_timeout();
      test_bad_cmd();
      test_false_start();
      test_reset_mid_write();
      test_bus_rules();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
